// File: rtl/link_list_walker_pkg.sv
// Shared defaults and state encoding for the per-port link-list walker.
package link_list_walker_pkg;

   localparam int ADDR_LENTH_DEF = 12;
   localparam int CNT_W_DEF      = 7;
   localparam int FIFO_DEPTH_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } walker_state_t;

endpackage

// File: rtl/link_list_walker_blk_addr_fifo.sv
// Synchronous first-word-fall-through FIFO holding {block address, last} entries.
// The head is visible combinationally from storage; an empty FIFO presents zero.
module blk_addr_fifo
   import link_list_walker_pkg::*;
#(
   parameter int DATA_WIDTH = ADDR_LENTH_DEF + 1,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
   localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  empty,
   output logic                  full,
   output logic [CW-1:0]         count
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         cnt;
   logic                  do_push;
   logic                  do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(FIFO_DEPTH - 1)) return '0;
      else                          return p + PW'(1);
   endfunction

   assign empty     = (cnt == '0);
   assign full      = (cnt == CW'(FIFO_DEPTH));
   assign do_pop    = pop & ~empty;
   // a pop in the same cycle frees the slot, so push is legal even when full
   assign do_push   = push & (~full | do_pop);
   assign head_data = empty ? '0 : mem[rd_ptr];
   assign count     = cnt;

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // entry storage, data only
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   overflow_chk: assert property (@(posedge clk) disable iff (rst) !(push && full && !do_pop));

endmodule

// File: rtl/link_list_walker.sv
// Per-port link-list walker: turns a packet descriptor into an ordered stream of
// block addresses by chasing next pointers through one link-list SRAM channel.
module link_list_walker
   import link_list_walker_pkg::*;
#(
   parameter int ADDR_LENTH = ADDR_LENTH_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iDescVld,
   output logic                  oDescRdy,
   input  logic [ADDR_LENTH-1:0] iHeadAddr,
   input  logic [CNT_W-1:0]      iBlkCnt,
   output logic                  oDescErr,
   output logic [ADDR_LENTH-1:0] oLaddr,
   output logic                  oLNxtAddrReq,
   input  logic [ADDR_LENTH-1:0] iLdata,
   input  logic                  iLdataVld,
   output logic [ADDR_LENTH-1:0] oBlkAddr,
   output logic                  oBlkLast,
   output logic                  oBlkVld,
   input  logic                  iBlkRdy
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int DW = ADDR_LENTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   walker_state_t         state;
   walker_state_t         state_next;
   logic [CNT_W-1:0]      remain_cnt;
   logic [CNT_W-1:0]      remain_next;
   logic [ADDR_LENTH-1:0] cur_addr;
   logic [ADDR_LENTH-1:0] cur_addr_next;
   logic                  req;
   logic                  req_next;
   logic                  desc_err;
   logic                  accept;
   logic                  desc_push;
   logic                  fetch_push;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  more_to_fetch;
   logic [DW-1:0]         push_data;
   logic [DW-1:0]         head_data;
   logic [CW-1:0]         fifo_count;
   logic [CW-1:0]         cnt_after;

   assign oDescRdy     = (state == IDLE) & ~fifo_full;
   assign accept       = iDescVld & oDescRdy;
   assign fifo_pop     = iBlkRdy & ~fifo_empty;
   assign oLaddr       = cur_addr;
   assign oLNxtAddrReq = req;
   assign oDescErr     = desc_err;
   assign oBlkAddr     = head_data[DW-1:1];
   assign oBlkLast     = head_data[0];
   assign oBlkVld      = ~fifo_empty;

   // next-state, FIFO push selection and lookup-request decision
   always_comb begin
      state_next    = state;
      remain_next   = remain_cnt;
      cur_addr_next = cur_addr;
      req_next      = 1'b0;
      desc_push     = 1'b0;
      fetch_push    = 1'b0;
      push_data     = '0;
      more_to_fetch = 1'b0;
      case (state)
         IDLE: begin
            if (accept && (iBlkCnt != '0)) begin
               desc_push = 1'b1;
               push_data = {iHeadAddr, (iBlkCnt == CNT_W'(1))};
               if (iBlkCnt != CNT_W'(1)) begin
                  state_next    = FETCH;
                  remain_next   = iBlkCnt - CNT_W'(1);
                  cur_addr_next = iHeadAddr;
               end
            end
         end
         FETCH: begin
            if (req && iLdataVld) begin
               fetch_push    = 1'b1;
               push_data     = {iLdata, (remain_cnt == CNT_W'(1))};
               cur_addr_next = iLdata;
               if (remain_cnt != '0) remain_next = remain_cnt - CNT_W'(1);
               more_to_fetch = (remain_cnt > CNT_W'(1));
               if (remain_cnt <= CNT_W'(1)) state_next = IDLE;
            end else begin
               more_to_fetch = (remain_cnt != '0);
            end
         end
         default: state_next = IDLE;
      endcase

      fifo_push = desc_push | fetch_push;
      cnt_after = fifo_count;
      if (fifo_push) cnt_after = cnt_after + CW'(1);
      if (fifo_pop)  cnt_after = cnt_after - CW'(1);

      // a lookup already in flight is held; otherwise issue only with a slot reserved for its answer
      if (state == FETCH) begin
         if (req && !iLdataVld) req_next = 1'b1;
         else                   req_next = more_to_fetch && (cnt_after < DEPTH_C);
      end
   end

   // FSM state register
   always_ff @(posedge iClk) begin
      if (iRst) state <= IDLE;
      else      state <= state_next;
   end

   // walk registers, lookup request and zero-length error pulse
   always_ff @(posedge iClk) begin
      if (iRst) begin
         remain_cnt <= '0;
         cur_addr   <= '0;
         req        <= 1'b0;
         desc_err   <= 1'b0;
      end else begin
         remain_cnt <= remain_next;
         cur_addr   <= cur_addr_next;
         req        <= req_next;
         desc_err   <= accept && (iBlkCnt == '0);
      end
   end

   blk_addr_fifo #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (iClk),
      .rst       (iRst),
      .push      (fifo_push),
      .push_data (push_data),
      .pop       (fifo_pop),
      .head_data (head_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_link_list_walker.sv
// Directed bench for link_list_walker with a link-SRAM responder model.
module tb_link_list_walker;
   import link_list_walker_pkg::*;

   localparam int AW = 12;
   localparam int CW = 7;
   localparam int FD = 4;

   logic          iClk = 1'b0;
   logic          iRst = 1'b1;
   logic          iDescVld = 1'b0;
   logic          oDescRdy;
   logic [AW-1:0] iHeadAddr = '0;
   logic [CW-1:0] iBlkCnt = '0;
   logic          oDescErr;
   logic [AW-1:0] oLaddr;
   logic          oLNxtAddrReq;
   logic [AW-1:0] iLdata = '0;
   logic          iLdataVld = 1'b0;
   logic [AW-1:0] oBlkAddr;
   logic          oBlkLast;
   logic          oBlkVld;
   logic          iBlkRdy = 1'b1;

   logic [AW-1:0] link_mem [0:4095];
   int            checks = 0;
   int            errors = 0;
   int            latency = 1;
   bit            resp_en = 1'b1;
   int            wcnt = 0;
   logic [AW:0]   popped[$];
   logic [AW-1:0] lookups[$];
   int            req_cycles = 0;
   int            err_pulses = 0;

   link_list_walker #(.ADDR_LENTH(AW), .CNT_W(CW), .FIFO_DEPTH(FD)) dut (
      .iClk(iClk), .iRst(iRst), .iDescVld(iDescVld), .oDescRdy(oDescRdy),
      .iHeadAddr(iHeadAddr), .iBlkCnt(iBlkCnt), .oDescErr(oDescErr),
      .oLaddr(oLaddr), .oLNxtAddrReq(oLNxtAddrReq), .iLdata(iLdata),
      .iLdataVld(iLdataVld), .oBlkAddr(oBlkAddr), .oBlkLast(oBlkLast),
      .oBlkVld(oBlkVld), .iBlkRdy(iBlkRdy)
   );

   always #5 iClk = ~iClk;

   // link SRAM model: answers a held request after 'latency' cycles with a 1-cycle valid
   always @(negedge iClk) begin
      if (resp_en) begin
         iLdataVld = 1'b0;
         if (iRst || !oLNxtAddrReq) begin
            wcnt = 0;
         end else begin
            wcnt++;
            if (wcnt >= latency) begin
               iLdata    = link_mem[oLaddr];
               iLdataVld = 1'b1;
               lookups.push_back(oLaddr);
               wcnt      = 0;
            end
         end
      end
   end

   // observe consumed entries, request cycles and error pulses
   always @(negedge iClk) begin
      if (!iRst) begin
         if (oBlkVld && iBlkRdy) popped.push_back({oBlkAddr, oBlkLast});
         if (oLNxtAddrReq) req_cycles++;
         if (oDescErr) err_pulses++;
      end
   end

   task automatic clear_log();
      popped.delete();
      lookups.delete();
      req_cycles = 0;
      err_pulses = 0;
   endtask

   task automatic send_desc(input logic [AW-1:0] head, input logic [CW-1:0] cnt);
      int n = 0;
      @(negedge iClk);
      while (!oDescRdy && n < 200) begin
         @(negedge iClk);
         n++;
      end
      if (!oDescRdy) begin
         checks++; errors++;
         $display("FAIL desc_rdy_timeout: oDescRdy=%b after %0d cycles, want 1", oDescRdy, n);
      end
      iDescVld  = 1'b1;
      iHeadAddr = head;
      iBlkCnt   = cnt;
      @(posedge iClk);
      #1;
      iDescVld  = 1'b0;
   endtask

   task automatic test_reset();
      iRst = 1'b1;
      repeat (3) @(posedge iClk);
      @(negedge iClk);
      checks++; if (oDescRdy !== 1'b1) begin errors++; $display("FAIL reset_desc_rdy: got %b want 1", oDescRdy); end
      checks++; if (oLNxtAddrReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", oLNxtAddrReq); end
      checks++; if (oLaddr !== 12'h000) begin errors++; $display("FAIL reset_laddr: got %h want 000", oLaddr); end
      checks++; if (oBlkVld !== 1'b0) begin errors++; $display("FAIL reset_blk_vld: got %b want 0", oBlkVld); end
      checks++; if (oBlkAddr !== 12'h000) begin errors++; $display("FAIL reset_blk_addr: got %h want 000", oBlkAddr); end
      checks++; if (oBlkLast !== 1'b0) begin errors++; $display("FAIL reset_blk_last: got %b want 0", oBlkLast); end
      checks++; if (oDescErr !== 1'b0) begin errors++; $display("FAIL reset_desc_err: got %b want 0", oDescErr); end
      iRst = 1'b0;
      @(posedge iClk);
      #1;
   endtask

   task automatic test_single_block();
      clear_log();
      iBlkRdy = 1'b1;
      send_desc(12'h010, 7'd1);
      @(negedge iClk);
      checks++; if (oDescRdy !== 1'b1) begin errors++; $display("FAIL single_rdy_next: got %b want 1", oDescRdy); end
      repeat (5) @(posedge iClk);
      #1;
      checks++; if (popped.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", popped.size()); end
      checks++; if (popped.size() > 0 && popped[0] !== {12'h010, 1'b1}) begin errors++; $display("FAIL single_entry: got %h want %h", popped[0], {12'h010, 1'b1}); end
      checks++; if (req_cycles != 0) begin errors++; $display("FAIL single_no_req: got %0d req cycles want 0", req_cycles); end
   endtask

   task automatic test_three_blocks();
      logic [AW:0] exp [3];
      exp[0] = {12'h005, 1'b0};
      exp[1] = {12'h1A0, 1'b0};
      exp[2] = {12'h033, 1'b1};
      clear_log();
      latency = 1;
      iBlkRdy = 1'b1;
      send_desc(12'h005, 7'd3);
      repeat (12) @(posedge iClk);
      #1;
      checks++; if (lookups.size() != 2) begin errors++; $display("FAIL three_lookups: got %0d want 2", lookups.size()); end
      checks++; if (lookups.size() >= 2 && (lookups[0] !== 12'h005 || lookups[1] !== 12'h1A0)) begin errors++; $display("FAIL three_lookup_addr: got %h,%h want 005,1a0", lookups[0], lookups[1]); end
      checks++; if (popped.size() != 3) begin errors++; $display("FAIL three_count: got %0d want 3", popped.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= popped.size() || popped[i] !== exp[i]) begin
            errors++; $display("FAIL three_entry%0d: got %h want %h", i, (i < popped.size()) ? popped[i] : 13'h0, exp[i]);
         end
      end
      checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL three_idle: got %b want IDLE", dut.state); end
   endtask

   task automatic test_stretched();
      int n = 0;
      clear_log();
      latency = 5;
      iBlkRdy = 1'b1;
      send_desc(12'h005, 7'd2);
      while (!oLNxtAddrReq && n < 20) begin
         @(posedge iClk);
         #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (oLNxtAddrReq !== 1'b1 || oLaddr !== 12'h005) begin
            errors++; $display("FAIL stretch_hold%0d: req=%b laddr=%h want req=1 laddr=005", i, oLNxtAddrReq, oLaddr);
         end
         @(posedge iClk);
         #1;
      end
      checks++; if (oLNxtAddrReq !== 1'b0) begin errors++; $display("FAIL stretch_req_drop: got %b want 0", oLNxtAddrReq); end
      repeat (5) @(posedge iClk);
      #1;
      checks++; if (lookups.size() != 1) begin errors++; $display("FAIL stretch_lookups: got %0d want 1", lookups.size()); end
      checks++; if (popped.size() != 2) begin errors++; $display("FAIL stretch_count: got %0d want 2", popped.size()); end
      checks++; if (popped.size() >= 2 && popped[1] !== {12'h1A0, 1'b1}) begin errors++; $display("FAIL stretch_entry: got %h want %h", popped[1], {12'h1A0, 1'b1}); end
      latency = 1;
   endtask

   task automatic test_backpressure();
      logic [AW:0] exp;
      for (int i = 0; i < 5; i++) link_mem[12'h100 + i] = AW'(12'h101 + i);
      clear_log();
      latency = 1;
      iBlkRdy = 1'b0;
      send_desc(12'h100, 7'd6);
      repeat (20) @(posedge iClk);
      #1;
      checks++; if (lookups.size() != 3) begin errors++; $display("FAIL bp_lookups_full: got %0d want 3", lookups.size()); end
      checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("FAIL bp_occupancy: got %0d want 4", dut.u_fifo.count); end
      checks++; if (oLNxtAddrReq !== 1'b0) begin errors++; $display("FAIL bp_no_req: got %b want 0", oLNxtAddrReq); end
      checks++; if (oBlkVld !== 1'b1 || oBlkAddr !== 12'h100) begin errors++; $display("FAIL bp_head: vld=%b addr=%h want 1,100", oBlkVld, oBlkAddr); end
      iBlkRdy = 1'b1;
      repeat (20) @(posedge iClk);
      #1;
      checks++; if (popped.size() != 6) begin errors++; $display("FAIL bp_count: got %0d want 6", popped.size()); end
      for (int i = 0; i < 6; i++) begin
         exp = {AW'(12'h100 + i), (i == 5)};
         checks++;
         if (i >= popped.size() || popped[i] !== exp) begin
            errors++; $display("FAIL bp_entry%0d: got %h want %h", i, (i < popped.size()) ? popped[i] : 13'h0, exp);
         end
      end
      checks++; if (lookups.size() != 5) begin errors++; $display("FAIL bp_lookups_total: got %0d want 5", lookups.size()); end
   endtask

   task automatic test_zero_count();
      clear_log();
      iBlkRdy = 1'b1;
      send_desc(12'h077, 7'd0);
      @(negedge iClk);
      checks++; if (oDescErr !== 1'b1) begin errors++; $display("FAIL zero_err_pulse: got %b want 1", oDescErr); end
      @(negedge iClk);
      checks++; if (oDescErr !== 1'b0) begin errors++; $display("FAIL zero_err_drop: got %b want 0", oDescErr); end
      repeat (5) @(posedge iClk);
      #1;
      checks++; if (err_pulses != 1) begin errors++; $display("FAIL zero_err_count: got %0d want 1", err_pulses); end
      checks++; if (popped.size() != 0 || oBlkVld !== 1'b0) begin errors++; $display("FAIL zero_no_entry: popped=%0d vld=%b want 0,0", popped.size(), oBlkVld); end
      checks++; if (req_cycles != 0) begin errors++; $display("FAIL zero_no_req: got %0d want 0", req_cycles); end
   endtask

   task automatic test_back_to_back();
      logic [AW:0] exp [4];
      exp[0] = {12'h200, 1'b0};
      exp[1] = {12'h210, 1'b1};
      exp[2] = {12'h300, 1'b0};
      exp[3] = {12'h310, 1'b1};
      link_mem[12'h200] = 12'h210;
      link_mem[12'h300] = 12'h310;
      clear_log();
      latency = 1;
      iBlkRdy = 1'b1;
      send_desc(12'h200, 7'd2);
      send_desc(12'h300, 7'd2);
      repeat (12) @(posedge iClk);
      #1;
      checks++; if (popped.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", popped.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= popped.size() || popped[i] !== exp[i]) begin
            errors++; $display("FAIL b2b_entry%0d: got %h want %h", i, (i < popped.size()) ? popped[i] : 13'h0, exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      clear_log();
      resp_en   = 1'b0;
      iLdataVld = 1'b0;
      iBlkRdy   = 1'b0;
      send_desc(12'h005, 7'd3);
      while (!oLNxtAddrReq && n < 20) begin
         @(negedge iClk);
         n++;
      end
      checks++; if (oLNxtAddrReq !== 1'b1) begin errors++; $display("FAIL rstmid_req_pending: got %b want 1", oLNxtAddrReq); end
      @(negedge iClk);
      iRst = 1'b1;
      @(negedge iClk);
      checks++; if (oLNxtAddrReq !== 1'b0) begin errors++; $display("FAIL rstmid_req_low: got %b want 0", oLNxtAddrReq); end
      iRst      = 1'b0;
      iLdata    = 12'h1A0;
      iLdataVld = 1'b1;
      @(posedge iClk);
      #1;
      iLdataVld = 1'b0;
      @(negedge iClk);
      checks++; if (oLNxtAddrReq !== 1'b0) begin errors++; $display("FAIL rstmid_req_after: got %b want 0", oLNxtAddrReq); end
      checks++; if (oBlkVld !== 1'b0) begin errors++; $display("FAIL rstmid_blk_vld: got %b want 0", oBlkVld); end
      checks++; if (oDescRdy !== 1'b1) begin errors++; $display("FAIL rstmid_desc_rdy: got %b want 1", oDescRdy); end
      checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rstmid_idle: got %b want IDLE", dut.state); end
      resp_en = 1'b1;
      iBlkRdy = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) link_mem[i] = '0;
      link_mem[12'h005] = 12'h1A0;
      link_mem[12'h1A0] = 12'h033;
      test_reset();
      test_single_block();
      test_three_blocks();
      test_stretched();
      test_backpressure();
      test_zero_count();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
